// File: rtl/huffman_packer_pkg.sv
// Shared types and constants for the Huffman bit packer.
package huffman_packer_pkg;

  localparam int unsigned ByteW  = 8;
  localparam int unsigned AccW   = 16;
  localparam int unsigned NumSym = 6;
  localparam logic [7:0]  SymMin = 8'd1;
  localparam logic [7:0]  SymMax = 8'd6;

  typedef enum logic [2:0] {
    StIdle,
    StLoad,
    StRun,
    StFlush,
    StDone
  } state_e;

endpackage

// File: rtl/huffman_code_len.sv
// Codeword length from its mask: number of set bits in an 8-bit mask.
module huffman_code_len (
  input  logic [7:0] mask_i,
  output logic [3:0] len_o
);

  always_comb begin
    len_o = 4'd0;
    for (int i = 0; i < 8; i++) begin
      len_o = len_o + {3'b000, mask_i[i]};
    end
  end

endmodule

// File: rtl/huffman_packer.sv
// Packs variable-length codewords for symbols 1..6 MSB-first into a byte stream,
// with a zero-padded final byte on flush.
module huffman_packer
  import huffman_packer_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             code_valid,
  input  logic [ByteW-1:0] HC1,
  input  logic [ByteW-1:0] HC2,
  input  logic [ByteW-1:0] HC3,
  input  logic [ByteW-1:0] HC4,
  input  logic [ByteW-1:0] HC5,
  input  logic [ByteW-1:0] HC6,
  input  logic [ByteW-1:0] M1,
  input  logic [ByteW-1:0] M2,
  input  logic [ByteW-1:0] M3,
  input  logic [ByteW-1:0] M4,
  input  logic [ByteW-1:0] M5,
  input  logic [ByteW-1:0] M6,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [7:0]       in_sym,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ByteW-1:0] out_byte,
  output logic             out_last,
  output logic             done,
  output logic             err_sym,
  output logic [15:0]      total_bits
);

  logic [ByteW-1:0] hc_in  [NumSym];
  logic [ByteW-1:0] m_in   [NumSym];
  logic [3:0]       len_in [NumSym];

  assign hc_in = '{HC1, HC2, HC3, HC4, HC5, HC6};
  assign m_in  = '{M1, M2, M3, M4, M5, M6};

  for (genvar g = 0; g < NumSym; g++) begin : g_len
    huffman_code_len u_code_len (
      .mask_i (m_in[g]),
      .len_o  (len_in[g])
    );
  end

  state_e           state_q, state_d;
  logic [ByteW-1:0] hc_q  [NumSym];
  logic [ByteW-1:0] hc_d  [NumSym];
  logic [3:0]       len_q [NumSym];
  logic [3:0]       len_d [NumSym];
  logic [AccW-1:0]  acc_q, acc_d;
  logic [3:0]       cnt_q, cnt_d;
  logic [15:0]      total_q, total_d;
  logic             err_q, err_d;

  logic             sym_ok;
  logic [ByteW-1:0] cur_code;
  logic [3:0]       cur_len;
  logic [4:0]       align_sh;
  logic [AccW-1:0]  code_left;
  logic [AccW-1:0]  code_ext;
  logic [16:0]      total_sum;

  always_comb begin
    cur_code = '0;
    cur_len  = '0;
    for (int k = 0; k < NumSym; k++) begin
      if (in_sym == 8'(k + 1)) begin
        cur_code = hc_q[k];
        cur_len  = len_q[k];
      end
    end
    sym_ok    = (in_sym >= SymMin) && (in_sym <= SymMax);
    // Left-align the low cur_len bits (upper code bits fall off), then place below cnt bits.
    align_sh  = 5'(AccW) - {1'b0, cur_len};
    code_left = {8'h00, cur_code} << align_sh;
    code_ext  = code_left >> cnt_q;
    total_sum = {1'b0, total_q} + {13'b0, cur_len};
  end

  always_comb begin
    state_d   = state_q;
    hc_d      = hc_q;
    len_d     = len_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    total_d   = total_q;
    err_d     = err_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    out_last  = 1'b0;
    done      = 1'b0;
    out_byte  = acc_q[AccW-1:AccW-ByteW];

    unique case (state_q)
      StIdle: begin
        if (code_valid) state_d = StLoad;
      end
      StLoad: begin
        hc_d    = hc_in;
        len_d   = len_in;
        acc_d   = '0;
        cnt_d   = '0;
        state_d = StRun;
      end
      StRun: begin
        in_ready  = !cnt_q[3] && !flush;
        out_valid = cnt_q[3];
        if (cnt_q[3]) begin
          if (out_ready) begin
            acc_d = acc_q << ByteW;
            cnt_d = cnt_q - 4'd8;
          end
        end else if (flush) begin
          state_d = StFlush;
        end else if (in_valid) begin
          if (sym_ok) begin
            acc_d   = acc_q | code_ext;
            cnt_d   = cnt_q + cur_len;
            total_d = total_sum[16] ? 16'hFFFF : total_sum[15:0];
          end else begin
            err_d = 1'b1;
          end
        end
      end
      StFlush: begin
        if (cnt_q != 4'd0) begin
          out_valid = 1'b1;
          out_last  = 1'b1;
          if (out_ready) begin
            acc_d   = '0;
            cnt_d   = '0;
            state_d = StDone;
          end
        end else begin
          state_d = StDone;
        end
      end
      StDone: begin
        done = 1'b1;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      acc_q   <= '0;
      cnt_q   <= '0;
      total_q <= '0;
      err_q   <= 1'b0;
      for (int k = 0; k < NumSym; k++) begin
        hc_q[k]  <= '0;
        len_q[k] <= '0;
      end
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      total_q <= total_d;
      err_q   <= err_d;
      hc_q    <= hc_d;
      len_q   <= len_d;
    end
  end

  assign err_sym    = err_q;
  assign total_bits = total_q;

endmodule

// File: tb/tb_huffman_packer.sv
// Bench for huffman_packer: bit-queue model checked every cycle plus literal byte expectations.
module tb_huffman_packer;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       code_valid = 1'b0;
  logic [7:0] hc_t [6];
  logic [7:0] m_t  [6];
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [7:0] in_sym = 8'd0;
  logic       flush = 1'b0;
  logic       out_valid;
  logic       out_ready = 1'b1;
  logic [7:0] out_byte;
  logic       out_last;
  logic       done;
  logic       err_sym;
  logic [15:0] total_bits;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  huffman_packer dut (
    .clk        (clk),
    .reset      (reset),
    .code_valid (code_valid),
    .HC1        (hc_t[0]),
    .HC2        (hc_t[1]),
    .HC3        (hc_t[2]),
    .HC4        (hc_t[3]),
    .HC5        (hc_t[4]),
    .HC6        (hc_t[5]),
    .M1         (m_t[0]),
    .M2         (m_t[1]),
    .M3         (m_t[2]),
    .M4         (m_t[3]),
    .M5         (m_t[4]),
    .M6         (m_t[5]),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_sym     (in_sym),
    .flush      (flush),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_byte   (out_byte),
    .out_last   (out_last),
    .done       (done),
    .err_sym    (err_sym),
    .total_bits (total_bits)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: phase 0 idle, 1 load, 2 run, 3 flush, 4 done; pending payload as a bit queue.
  int         phase = 0;
  bit         q[$];
  logic [7:0] mhc [6];
  int         mlen [6];
  int         mtotal = 0;
  bit         merr = 1'b0;
  logic [8:0] got[$];

  always @(negedge clk) begin
    bit         exp_ov, exp_ir;
    logic [7:0] eb;
    int         s;
    exp_ov = (phase == 2 && q.size() >= 8) || (phase == 3 && q.size() > 0);
    exp_ir = (phase == 2) && (q.size() < 8) && !flush;
    chk("out_valid", out_valid, exp_ov);
    chk("in_ready", in_ready, exp_ir);
    chk("done", done, phase == 4);
    chk("err_sym", err_sym, merr);
    chk("total_bits", total_bits, mtotal);
    if (exp_ov) begin
      eb = 8'h00;
      for (int i = 0; i < 8; i++) if (i < q.size()) eb[7-i] = q[i];
      chk("out_byte", out_byte, eb);
      chk("out_last", out_last, phase == 3);
    end
    if (out_valid && out_ready && !reset) got.push_back({out_last, out_byte});

    if (reset) begin
      phase = 0; q.delete(); mtotal = 0; merr = 1'b0;
    end else begin
      case (phase)
        0: if (code_valid) phase = 1;
        1: begin
          for (int k = 0; k < 6; k++) begin
            mhc[k]  = hc_t[k];
            mlen[k] = $countones(m_t[k]);
          end
          q.delete();
          phase = 2;
        end
        2: begin
          if (q.size() >= 8) begin
            if (out_ready) for (int i = 0; i < 8; i++) void'(q.pop_front());
          end else if (flush) begin
            phase = 3;
          end else if (in_valid) begin
            s = int'(in_sym);
            if (s >= 1 && s <= 6) begin
              for (int b = mlen[s-1] - 1; b >= 0; b--) q.push_back(mhc[s-1][b]);
              mtotal = mtotal + mlen[s-1];
              if (mtotal > 65535) mtotal = 65535;
            end else begin
              merr = 1'b1;
            end
          end
        end
        3: begin
          if (q.size() > 0) begin
            if (out_ready) begin q.delete(); phase = 4; end
          end else begin
            phase = 4;
          end
        end
        default: ;
      endcase
    end
  end

  task automatic set_std_table();
    hc_t = '{8'h00, 8'h02, 8'h06, 8'h0E, 8'h1E, 8'h1F};
    m_t  = '{8'h01, 8'h03, 8'h07, 8'h0F, 8'h1F, 8'h1F};
  endtask

  task automatic do_reset();
    code_valid = 1'b0; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    got.delete();
  endtask

  task automatic start();
    code_valid = 1'b1;
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic send_sym(input logic [7:0] s);
    int n = 0;
    in_valid = 1'b1; in_sym = s;
    @(negedge clk);
    while (!in_ready && n < 50) begin @(negedge clk); n++; end
    if (!in_ready) chk("send_timeout", in_ready, 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic do_flush();
    int n = 0;
    flush = 1'b1;
    while (!done && n < 60) begin @(posedge clk); #1; n++; end
    chk("flush_done", done, 1);
    flush = 1'b0;
  endtask

  initial begin
    set_std_table();
    do_reset();
    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_byte", out_byte, 0);
    chk("rst_total", total_bits, 0);

    // Symbols 1,2,3,4 -> 0x5B then 0x80 last
    start();
    send_sym(1); send_sym(2); send_sym(3); send_sym(4);
    do_flush();
    chk("a_count", got.size(), 2);
    chk("a_b0", got[0], 9'h05B);
    chk("a_b1", got[1], 9'h180);
    chk("a_total", total_bits, 10);

    // Six symbol 6 -> FF FF FF FC(last)
    do_reset(); start();
    for (int i = 0; i < 6; i++) send_sym(6);
    do_flush();
    chk("b_count", got.size(), 4);
    chk("b_b0", got[0], 9'h0FF);
    chk("b_b2", got[2], 9'h0FF);
    chk("b_b3", got[3], 9'h1FC);
    chk("b_total", total_bits, 30);

    // Backpressure: eight zeros held while out_ready low
    do_reset(); start();
    out_ready = 1'b0;
    for (int i = 0; i < 8; i++) send_sym(1);
    repeat (3) @(posedge clk);
    #1;
    chk("c_hold_valid", out_valid, 1);
    chk("c_hold_byte", out_byte, 8'h00);
    chk("c_hold_ready", in_ready, 0);
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk("c_one_byte", got.size(), 1);
    do_flush();
    chk("c_no_extra", got.size(), 1);
    chk("c_b0", got[0], 9'h000);

    // Reset with 5 bits buffered, then restart with 2,7,2
    do_reset(); start();
    send_sym(1); send_sym(4);
    chk("d_total_pre", total_bits, 5);
    do_reset();
    chk("d_out_valid", out_valid, 0);
    chk("d_out_last", out_last, 0);
    chk("d_out_byte", out_byte, 0);
    chk("d_total", total_bits, 0);
    chk("d_done", done, 0);
    chk("d_no_byte", got.size(), 0);
    start();
    send_sym(2); send_sym(7); send_sym(2);
    do_flush();
    chk("e_err", err_sym, 1);
    chk("e_count", got.size(), 1);
    chk("e_b0", got[0], 9'h1A0);
    chk("e_total", total_bits, 4);

    // total_bits saturation with an 8-bit code streamed continuously
    do_reset();
    hc_t[5] = 8'hFF; m_t[5] = 8'hFF;
    start();
    in_valid = 1'b1; in_sym = 8'd6;
    repeat (20000) @(posedge clk);
    #1;
    in_valid = 1'b0;
    chk("f_total_sat", total_bits, 16'hFFFF);
    chk("f_err", err_sym, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
